tone_voice_gen: RTL and testbench

//  Single-voice tone generator for the piano/music-box audio path: phase-accumulator oscillator
//  (4 selectable waveforms) times a per-period decaying amplitude envelope with note-on/note-off

---
 rtl/tone_voice_gen_if.sv | 33 +++
 rtl/tone_voice_gen.sv | 174 +++++++++++++++++
 tb/tb_tone_voice_gen.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tone_voice_gen_if.sv
// ---------------------------------------------------------------------------
// tone_voice_gen_if
// Control and sample bundle for one tone voice.
//   note_start  : 1-cycle pulse, (re)start a note with phase_inc/mode_in
//   note_stop   : 1-cycle pulse, begin the release phase
//   phase_inc   : tuning word, f_out = phase_inc * f_clk / 2^PHASE_W
//   mode_in     : 0 square, 1 triangle, 2 sawtooth, 3 pulse 25%
//   audio_out   : signed 32-bit registered sample (wave * envelope)
//   active      : high while a note is playing or releasing
//   wrap_tick   : 1-cycle pulse on phase accumulator overflow
// master drives the controls, slave is the voice itself.
// ---------------------------------------------------------------------------
interface tone_voice_gen_if #(
  parameter int PHASE_W = 32
);
  logic                 note_start;
  logic                 note_stop;
  logic [PHASE_W-1:0]   phase_inc;
  logic [1:0]           mode_in;
  logic signed [31:0]   audio_out;
  logic                 active;
  logic                 wrap_tick;

  modport master (
    output note_start, note_stop, phase_inc, mode_in,
    input  audio_out, active, wrap_tick
  );

  modport slave (
    input  note_start, note_stop, phase_inc, mode_in,
    output audio_out, active, wrap_tick
  );
endinterface

// File: rtl/tone_voice_gen.sv
// ---------------------------------------------------------------------------
// tone_voice_gen
// Single-voice tone generator: phase-accumulator oscillator with four
// waveforms, multiplied by a per-period decaying envelope.
// Ports:
//   clock   : system clock, all logic on rising edge
//   resetn  : synchronous active-low reset
//   bus     : tone_voice_gen_if.slave (note controls in, sample/status out)
// Envelope behaviour:
//   PLAY    : each wrap env -= max(env>>DECAY_SHIFT,1), floor at SUSTAIN
//   RELEASE : each wrap env -= max(env>>REL_SHIFT,1); below ENV_FLOOR the
//             voice falls back to IDLE with env and phase cleared.
// ---------------------------------------------------------------------------
module tone_voice_gen #(
  parameter int PHASE_W     = 32,
  parameter int ENV_MAX     = 65535,
  parameter int SUSTAIN     = 16384,
  parameter int DECAY_SHIFT = 4,
  parameter int REL_SHIFT   = 2,
  parameter int ENV_FLOOR   = 256
) (
  input  logic             clock,
  input  logic             resetn,
  tone_voice_gen_if.slave  bus
);

  localparam logic [15:0] ENV_MAX_V   = 16'(ENV_MAX);
  localparam logic [15:0] SUSTAIN_V   = 16'(SUSTAIN);
  localparam logic [15:0] ENV_FLOOR_V = 16'(ENV_FLOOR);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [PHASE_W-1:0]  inc_q,   inc_d;
  logic [1:0]          mode_q,  mode_d;
  logic [15:0]         env_q,   env_d;
  logic signed [31:0]  audio_q, audio_d;
  logic                wrap_q,  wrap_d;

  // Accumulator with explicit carry; the carry is the wrap event.
  logic [PHASE_W:0]    phase_sum;
  logic                carry;
  assign phase_sum = {1'b0, phase_q} + {1'b0, inc_q};
  assign carry     = phase_sum[PHASE_W];

  // ---------------- waveform from the registered phase/mode ----------------
  logic [15:0]         p;
  logic [14:0]         tri_u;
  logic signed [16:0]  wave;

  assign p     = phase_q[PHASE_W-1 -: 16];
  assign tri_u = p[15] ? ~p[14:0] : p[14:0];

  always_comb begin
    wave = '0;
    case (mode_q)
      2'd0:    wave = p[15] ? -17'sd32767 : 17'sd32767;
      2'd1:    wave = $signed({1'b0, tri_u, 1'b0}) - 17'sd32767;
      2'd2:    wave = $signed({~p[15], ~p[15], p[14:0]});
      default: wave = (p < 16'h4000) ? 17'sd32767 : -17'sd32767;
    endcase
  end

  // 32-bit product carries the same low bits as the full 17x17 product,
  // and the magnitude never exceeds 32768*65535 so nothing is lost.
  logic signed [31:0]  prod;
  assign prod = 32'(wave) * $signed({16'b0, env_q});

  // ---------------- envelope step candidates ----------------
  logic [15:0] play_dec, rel_dec;
  logic [15:0] play_env, rel_env;

  always_comb begin
    play_dec = env_q >> DECAY_SHIFT;
    if (play_dec == 16'd0) play_dec = 16'd1;
    rel_dec = env_q >> REL_SHIFT;
    if (rel_dec == 16'd0) rel_dec = 16'd1;

    // Compare before subtracting so the envelope can never wrap below zero.
    if (env_q < play_dec || (env_q - play_dec) < SUSTAIN_V)
      play_env = SUSTAIN_V;
    else
      play_env = env_q - play_dec;

    if (env_q < rel_dec)
      rel_env = 16'd0;
    else
      rel_env = env_q - rel_dec;
  end

  // ---------------- next state / outputs ----------------
  logic start_ok;
  assign start_ok = bus.note_start && (bus.phase_inc != '0);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    inc_d   = inc_q;
    mode_d  = mode_q;
    env_d   = env_q;
    wrap_d  = 1'b0;

    // Output sample uses the registers as they stand this cycle.
    audio_d = (state_q != ST_IDLE) ? prod : 32'sd0;

    if (start_ok) begin
      // A valid start always wins, also over a simultaneous stop.
      state_d = ST_PLAY;
      phase_d = '0;
      env_d   = ENV_MAX_V;
      inc_d   = bus.phase_inc;
      mode_d  = bus.mode_in;
    end else begin
      case (state_q)
        ST_IDLE: begin
          phase_d = '0;
        end
        ST_PLAY: begin
          phase_d = phase_sum[PHASE_W-1:0];
          wrap_d  = carry;
          if (carry) env_d = play_env;
          if (bus.note_stop) state_d = ST_RELEASE;
        end
        ST_RELEASE: begin
          phase_d = phase_sum[PHASE_W-1:0];
          wrap_d  = carry;
          if (carry) begin
            env_d = rel_env;
            if (rel_env < ENV_FLOOR_V) begin
              state_d = ST_IDLE;
              env_d   = 16'd0;
              phase_d = '0;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          phase_d = '0;
          env_d   = 16'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      inc_q   <= '0;
      mode_q  <= 2'd0;
      env_q   <= 16'd0;
      audio_q <= 32'sd0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      inc_q   <= inc_d;
      mode_q  <= mode_d;
      env_q   <= env_d;
      audio_q <= audio_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.audio_out = audio_q;
  assign bus.active    = (state_q != ST_IDLE);
  assign bus.wrap_tick = wrap_q;

endmodule

// File: tb/tb_tone_voice_gen.sv
// ---------------------------------------------------------------------------
// tb_tone_voice_gen
// Directed scenarios with spec-derived constants plus a randomized stream
// checked against a behavioural model of the voice (integer phase, envelope
// arithmetic, note on/release flags).
// ---------------------------------------------------------------------------
module tb_tone_voice_gen;

  localparam int    PW          = 32;
  localparam longint TWO_PW     = 64'h1_0000_0000;
  localparam int    ENV_MAX     = 65535;
  localparam int    SUSTAIN     = 16384;
  localparam int    DECAY_SHIFT = 4;
  localparam int    REL_SHIFT   = 2;
  localparam int    ENV_FLOOR   = 256;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  tone_voice_gen_if #(.PHASE_W(PW)) bus();

  tone_voice_gen #(
    .PHASE_W(PW), .ENV_MAX(ENV_MAX), .SUSTAIN(SUSTAIN),
    .DECAY_SHIFT(DECAY_SHIFT), .REL_SHIFT(REL_SHIFT), .ENV_FLOOR(ENV_FLOOR)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- behavioural model ----------------
  longint m_phase, m_inc;
  int     m_mode, m_env, m_audio;
  bit     m_sounding, m_releasing, m_wrap;

  function automatic int wave_of(longint ph, int md);
    int p;
    p = int'(ph >> (PW - 16));
    case (md)
      0:       return (p >= 32768) ? -32767 : 32767;
      1:       return (p < 32768) ? (2 * p - 32767) : (2 * (65535 - p) - 32767);
      2:       return p - 32768;
      default: return (p < 16384) ? 32767 : -32767;
    endcase
  endfunction

  task automatic model_step(input bit rn, input bit st, input bit sp,
                            input longint inc, input int md);
    longint sum;
    bit carry, was_rel;
    int dec;
    if (!rn) begin
      m_phase = 0; m_inc = 0; m_mode = 0; m_env = 0; m_audio = 0;
      m_sounding = 0; m_releasing = 0; m_wrap = 0;
      return;
    end
    m_audio = m_sounding ? wave_of(m_phase, m_mode) * m_env : 0;
    sum   = m_phase + m_inc;
    carry = (sum >= TWO_PW);
    m_wrap = 0;
    if (st && inc != 0) begin
      m_sounding = 1; m_releasing = 0;
      m_phase = 0; m_env = ENV_MAX; m_inc = inc; m_mode = md;
    end else if (m_sounding) begin
      m_phase = sum % TWO_PW;
      m_wrap  = carry;
      was_rel = m_releasing;
      if (carry && !was_rel) begin
        dec = m_env >> DECAY_SHIFT;
        if (dec < 1) dec = 1;
        m_env = (m_env - dec < SUSTAIN) ? SUSTAIN : m_env - dec;
      end
      if (carry && was_rel) begin
        dec = m_env >> REL_SHIFT;
        if (dec < 1) dec = 1;
        m_env = (m_env - dec < 0) ? 0 : m_env - dec;
        if (m_env < ENV_FLOOR) begin
          m_sounding = 0; m_releasing = 0; m_env = 0; m_phase = 0;
        end
      end
      if (sp && !was_rel) m_releasing = 1;
    end
  endtask

  // One clock: drive at negedge, step the model, sample #1 after posedge.
  task automatic tick(input bit rn, input bit st, input bit sp,
                      input logic [31:0] inc, input logic [1:0] md);
    @(negedge clock);
    resetn         = rn;
    bus.note_start = st;
    bus.note_stop  = sp;
    bus.phase_inc  = inc;
    bus.mode_in    = md;
    model_step(rn, st, sp, longint'(inc), int'(md));
    @(posedge clock);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    n_checks++; if (bus.audio_out !== 32'sd0) $display("FAIL reset_audio: got %0d want 0", bus.audio_out); else n_pass++;
    n_checks++; if (bus.active !== 1'b0) $display("FAIL reset_active: got %b want 0", bus.active); else n_pass++;
    tick(1, 1, 0, 32'h1000_0000, 2'd0);
    for (int i = 0; i < 5; i++) tick(1, 0, 0, 32'h1000_0000, 2'd0);
    for (int i = 0; i < 2; i++) begin
      tick(0, 1, 0, 32'h1000_0000, 2'd1);
      n_checks++; if (bus.audio_out !== 32'sd0) $display("FAIL midnote_reset_audio[%0d]: got %0d want 0", i, bus.audio_out); else n_pass++;
      n_checks++; if (bus.active !== 1'b0) $display("FAIL midnote_reset_active[%0d]: got %b want 0", i, bus.active); else n_pass++;
      n_checks++; if (bus.wrap_tick !== 1'b0) $display("FAIL midnote_reset_wrap[%0d]: got %b want 0", i, bus.wrap_tick); else n_pass++;
    end
    tick(1, 0, 0, 0, 0);
    n_checks++; if (bus.active !== 1'b0) $display("FAIL start_ignored_in_reset: active got %b want 0", bus.active); else n_pass++;
    n_checks++; if (bus.audio_out !== 32'sd0) $display("FAIL post_reset_audio: got %0d want 0", bus.audio_out); else n_pass++;
  endtask

  task automatic test_square;
    int expv;
    tick(1, 1, 0, 32'h1000_0000, 2'd0);
    for (int k = 1; k <= 17; k++) begin
      tick(1, 0, 0, 32'h1000_0000, 2'd0);
      if (k <= 8)       expv = 2147385345;
      else if (k <= 16) expv = -2147385345;
      else              expv = 2013204480;
      n_checks++; if (bus.audio_out !== expv) $display("FAIL square_sample[%0d]: got %0d want %0d", k, bus.audio_out, expv); else n_pass++;
      n_checks++; if (bus.wrap_tick !== (k == 16)) $display("FAIL square_wrap[%0d]: got %b want %b", k, bus.wrap_tick, (k == 16)); else n_pass++;
    end
  endtask

  task automatic test_saw_pulse;
    int expv, highs;
    tick(1, 1, 0, 32'h1000_0000, 2'd2);
    for (int k = 1; k <= 16; k++) begin
      tick(1, 0, 0, 32'h1000_0000, 2'd2);
      expv = (-32768 + 4096 * (k - 1)) * 65535;
      n_checks++; if (bus.audio_out !== expv) $display("FAIL saw_sample[%0d]: got %0d want %0d", k, bus.audio_out, expv); else n_pass++;
    end
    tick(1, 1, 0, 32'h1000_0000, 2'd3);
    highs = 0;
    for (int k = 1; k <= 16; k++) begin
      tick(1, 0, 0, 32'h1000_0000, 2'd3);
      expv = (k <= 4) ? 2147385345 : -2147385345;
      if (bus.audio_out > 0) highs++;
      n_checks++; if (bus.audio_out !== expv) $display("FAIL pulse_sample[%0d]: got %0d want %0d", k, bus.audio_out, expv); else n_pass++;
    end
    n_checks++; if (highs !== 4) $display("FAIL pulse_high_count: got %0d want 4", highs); else n_pass++;
  endtask

  task automatic test_decay_release;
    int e, want_wraps, got_wraps, dec, cyc;
    tick(1, 1, 0, 32'h4000_0000, 2'd0);
    for (int i = 0; i < 300; i++) begin
      tick(1, 0, 0, 32'h4000_0000, 2'd0);
      if (i >= 292 && bus.audio_out > 0) begin
        n_checks++; if (bus.audio_out !== 536854528) $display("FAIL sustain_level[%0d]: got %0d want 536854528", i, bus.audio_out); else n_pass++;
      end
    end
    n_checks++; if (bus.audio_out !== m_audio) $display("FAIL decay_vs_model: got %0d want %0d", bus.audio_out, m_audio); else n_pass++;
    e = SUSTAIN; want_wraps = 0;
    do begin
      dec = e >> REL_SHIFT; if (dec < 1) dec = 1;
      e = e - dec; want_wraps++;
    end while (e >= ENV_FLOOR);
    tick(1, 0, 1, 32'h4000_0000, 2'd0);
    got_wraps = 0; cyc = 0;
    while (bus.active === 1'b1 && cyc < 2000) begin
      tick(1, 0, 0, 32'h4000_0000, 2'd0);
      if (bus.wrap_tick === 1'b1) got_wraps++;
      cyc++;
    end
    n_checks++; if (cyc >= 2000) $display("FAIL release_timeout: active still %b after %0d cycles", bus.active, cyc); else n_pass++;
    n_checks++; if (got_wraps !== want_wraps) $display("FAIL release_wraps: got %0d want %0d", got_wraps, want_wraps); else n_pass++;
    tick(1, 0, 0, 32'h4000_0000, 2'd0);
    n_checks++; if (bus.audio_out !== 32'sd0) $display("FAIL idle_audio: got %0d want 0", bus.audio_out); else n_pass++;
  endtask

  task automatic test_start_stop;
    tick(1, 1, 1, 32'h4000_0000, 2'd0);
    n_checks++; if (bus.active !== 1'b1) $display("FAIL startstop_active: got %b want 1", bus.active); else n_pass++;
    tick(1, 0, 0, 32'h4000_0000, 2'd0);
    n_checks++; if (bus.audio_out !== 2147385345) $display("FAIL startstop_env: got %0d want 2147385345", bus.audio_out); else n_pass++;
    for (int i = 0; i < 150; i++) tick(1, 0, 0, 32'h4000_0000, 2'd0);
    n_checks++; if (bus.active !== 1'b1) $display("FAIL startstop_still_play: got %b want 1", bus.active); else n_pass++;
    tick(1, 1, 0, 32'h0, 2'd2);
    for (int i = 0; i < 8; i++) begin
      tick(1, 0, 0, 32'h0, 2'd2);
      n_checks++; if (bus.audio_out !== m_audio) $display("FAIL zero_inc_ignored[%0d]: got %0d want %0d", i, bus.audio_out, m_audio); else n_pass++;
    end
    tick(1, 0, 1, 32'h0, 2'd0);
    for (int i = 0; i < 12; i++) tick(1, 0, 0, 32'h0, 2'd0);
    tick(1, 1, 0, 32'h1000_0000, 2'd2);
    n_checks++; if (bus.active !== 1'b1) $display("FAIL retrigger_active: got %b want 1", bus.active); else n_pass++;
    tick(1, 0, 0, 32'h1000_0000, 2'd2);
    n_checks++; if (bus.audio_out !== -2147450880) $display("FAIL retrigger_sample: got %0d want -2147450880", bus.audio_out); else n_pass++;
  endtask

  task automatic test_random;
    int errs;
    bit rn, st, sp;
    logic [31:0] inc;
    logic [1:0] md;
    int r;
    errs = 0;
    for (int c = 0; c < 40000; c++) begin
      rn = ($urandom_range(0, 2999) != 0);
      st = ($urandom_range(0, 299) == 0);
      sp = ($urandom_range(0, 149) == 0);
      r  = $urandom_range(0, 9);
      if (r == 0)      inc = 32'h0;
      else if (r == 1) inc = $urandom_range(1, 1 << 20);
      else             inc = ($urandom >> $urandom_range(0, 3)) | 32'h0100_0000;
      md = 2'($urandom_range(0, 3));
      tick(rn, st, sp, inc, md);
      n_checks++; if (bus.audio_out !== m_audio) begin $display("FAIL rand_audio@%0d: got %0d want %0d", c, bus.audio_out, m_audio); errs++; end else n_pass++;
      n_checks++; if (bus.active !== m_sounding) begin $display("FAIL rand_active@%0d: got %b want %b", c, bus.active, m_sounding); errs++; end else n_pass++;
      n_checks++; if (bus.wrap_tick !== m_wrap) begin $display("FAIL rand_wrap@%0d: got %b want %b", c, bus.wrap_tick, m_wrap); errs++; end else n_pass++;
      if (errs > 20) break;
    end
  endtask

  initial begin
    bus.note_start = 1'b0;
    bus.note_stop  = 1'b0;
    bus.phase_inc  = '0;
    bus.mode_in    = 2'd0;
    test_reset();
    test_square();
    test_saw_pulse();
    test_decay_release();
    test_start_stop();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
